// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants and helpers for the round-robin selector arbiter.
package rr_sel_arbiter_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
    localparam int S_DEF = 2;

    // The output slot can take a new word when it is empty or being drained.
    function automatic logic slot_load(input logic out_valid, input logic out_ready);
        return !out_valid || out_ready;
    endfunction

    function automatic int unsigned next_idx(input int unsigned g, input int unsigned m = M_DEF);
        return (g == m - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Requester/consumer handshake bundle; req_lock exists only with RR_SEL_LOCK_EN.
interface rr_sel_arbiter_if
    import rr_sel_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int S = S_DEF
);
    logic [M-1:0]   req_valid;
    logic [M-1:0]   req_ready;
    logic [M*N-1:0] req_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [S-1:0]   out_sel;
`ifdef RR_SEL_LOCK_EN
    logic [M-1:0]   req_lock;
`endif

    modport slave (
`ifdef RR_SEL_LOCK_EN
        input  req_lock,
`endif
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
`ifdef RR_SEL_LOCK_EN
        output req_lock,
`endif
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/rr_sel_arbiter_mux.sv
// M-to-1 word selector over a flat M*N bus; codes at or above M yield zero.
module muxMto1 #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int S = 2
) (
    input  logic [M*N-1:0] D,
    input  logic [S-1:0]   SEL,
    output logic [N-1:0]   Z
);
    logic [N-1:0] w_words [2**S];

    generate
        for (genvar gi = 0; gi < 2**S; gi++) begin : g_word
            if (gi < M) begin : g_used
                assign w_words[gi] = D[N*gi +: N];
            end else begin : g_unused
                assign w_words[gi] = '0;
            end
        end
    endgenerate

    assign Z = w_words[SEL];
endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter feeding a registered single-entry output slot.
// Optional burst lock on the granted requester: define RR_SEL_LOCK_EN.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int S = S_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rr_sel_arbiter_if.slave bus
);
    logic [S-1:0] r_ptr;
    logic         r_out_valid;
    logic [N-1:0] r_out_data;
    logic [S-1:0] r_out_sel;

    logic         w_load;
    logic         w_any;
    logic [S-1:0] w_grant;
    logic [S-1:0] w_ptr_next;
    logic [N-1:0] w_mux_z;
    int           w_idx;

    assign w_load = slot_load(r_out_valid, bus.out_ready);

    // Scan from the far end back toward ptr so the closest requester wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = M - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= M) begin
                w_idx = w_idx - M;
            end
            if (bus.req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = S'(w_idx);
            end
        end
    end

    always_comb begin
        w_ptr_next = S'(next_idx(32'(w_grant), M));
`ifdef RR_SEL_LOCK_EN
        if (bus.req_lock[w_grant]) begin
            w_ptr_next = w_grant;
        end
`endif
    end

    muxMto1 #(.N(N), .M(M), .S(S)) u_mux (
        .D   (bus.req_data),
        .SEL (w_grant),
        .Z   (w_mux_z)
    );

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_ready
            assign bus.req_ready[gi] = !rst && w_load && w_any && (w_grant == S'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_data  <= w_mux_z;
                r_out_sel   <= w_grant;
                r_out_valid <= 1'b1;
                r_ptr       <= w_ptr_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule
